// File: rtl/palette_lut.sv
// palette_lut: runtime-writable colour palette with a 2-stage registered read
// pipeline and global brightness scaling driven by a frame-synchronous fade
// engine.
// Optional build macro PALETTE_COLORKEY_EN adds parameter KEY_RGB and output
// 'transparent', raised alongside rgb_valid when the unscaled entry matches
// the colour key.
module palette_lut #(
    parameter int INDEX_W  = 4,
    parameter int COLOR_W  = 4,
    parameter int LVL_W    = 3,
    parameter int FADE_DIV = 2,
    parameter logic [(2**INDEX_W)*3*COLOR_W-1:0] DEFAULT_PAL = '0
`ifdef PALETTE_COLORKEY_EN
    ,
    parameter logic [3*COLOR_W-1:0] KEY_RGB = {{COLOR_W{1'b1}}, {COLOR_W{1'b0}}, {COLOR_W{1'b1}}}
`endif
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 rd_valid_i,
    input  logic [INDEX_W-1:0]   rd_index,
    input  logic                 wr_en,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [3*COLOR_W-1:0] wr_rgb,
    input  logic                 fade_start,
    input  logic                 fade_dir,
    input  logic                 frame_tick,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 rgb_valid,
    output logic [LVL_W:0]       level,
    output logic                 fade_busy,
    output logic                 fade_done
`ifdef PALETTE_COLORKEY_EN
    ,
    output logic                 transparent
`endif
);

    localparam int NUM_ENTRIES = 2**INDEX_W;
    localparam int EW          = 3*COLOR_W;
    localparam int CNT_W       = $clog2(FADE_DIV + 1);
    localparam logic [LVL_W:0] FULL_LVL = {1'b1, {LVL_W{1'b0}}};
    localparam logic [LVL_W:0] ZERO_LVL = {(LVL_W+1){1'b0}};
    localparam logic [LVL_W:0] ONE_LVL  = {{LVL_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FADING = 2'd1,
        ST_DONE   = 2'd2
    } fade_state_t;

    logic [EW-1:0]      pal_r [NUM_ENTRIES];
    logic [EW-1:0]      s1_rgb_r;
    logic               s1_valid_r;
    logic [COLOR_W-1:0] red_r, green_r, blue_r;
    logic               rgb_valid_r;

    fade_state_t        state_r, state_nx_s;
    logic [LVL_W:0]     level_r, level_nx_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
    logic               dir_r, dir_nx_s;
    logic               fade_busy_r, fade_done_r;
    logic [LVL_W:0]     target_s;

    // Full-width product, then drop the LVL_W fraction bits (truncation).
    function automatic logic [COLOR_W-1:0] scale_chan(input logic [COLOR_W-1:0] c,
                                                       input logic [LVL_W:0]   lvl);
        logic [COLOR_W+LVL_W:0] prod;
        prod = {{(LVL_W+1){1'b0}}, c} * {{COLOR_W{1'b0}}, lvl};
        return prod[LVL_W +: COLOR_W];
    endfunction

    // Palette storage: reset to DEFAULT_PAL (entry 0 in the MSBs), unconditional writes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                pal_r[i] <= DEFAULT_PAL[(NUM_ENTRIES-1-i)*EW +: EW];
            end
        end else if (wr_en) begin
            pal_r[wr_index] <= wr_rgb;
        end
    end

    // Stage 1: look up the entry; a same-cycle write lands after this read, so the old value is seen.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_rgb_r   <= {EW{1'b0}};
            s1_valid_r <= 1'b0;
        end else begin
            s1_rgb_r   <= pal_r[rd_index];
            s1_valid_r <= rd_valid_i;
        end
    end

    // Stage 2: scale by the current level; colour regs only load on valid data so they hold otherwise.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            red_r       <= {COLOR_W{1'b0}};
            green_r     <= {COLOR_W{1'b0}};
            blue_r      <= {COLOR_W{1'b0}};
            rgb_valid_r <= 1'b0;
        end else begin
            rgb_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                red_r   <= scale_chan(s1_rgb_r[2*COLOR_W +: COLOR_W], level_r);
                green_r <= scale_chan(s1_rgb_r[COLOR_W +: COLOR_W], level_r);
                blue_r  <= scale_chan(s1_rgb_r[0 +: COLOR_W], level_r);
            end else begin
                red_r   <= red_r;
                green_r <= green_r;
                blue_r  <= blue_r;
            end
        end
    end

`ifdef PALETTE_COLORKEY_EN
    logic transparent_r;

    // Colour-key flag compares the unscaled entry, so it does not depend on level.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            transparent_r <= 1'b0;
        end else begin
            transparent_r <= s1_valid_r && (s1_rgb_r == KEY_RGB);
        end
    end

    assign transparent = transparent_r;
`endif

    // Fade engine next-state: target latch, tick prescaler and saturating level step.
    always_comb begin
        state_nx_s = state_r;
        level_nx_s = level_r;
        cnt_nx_s   = cnt_r;
        dir_nx_s   = dir_r;
        target_s   = dir_r ? FULL_LVL : ZERO_LVL;
        case (state_r)
            ST_IDLE: begin
                if (fade_start) begin
                    dir_nx_s = fade_dir;
                    cnt_nx_s = {CNT_W{1'b0}};
                    if ((fade_dir ? FULL_LVL : ZERO_LVL) == level_r) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_FADING;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FADING: begin
                if (frame_tick) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_nx_s = {CNT_W{1'b0}};
                        if (dir_r && (level_r != FULL_LVL)) begin
                            level_nx_s = level_r + ONE_LVL;
                        end else if (!dir_r && (level_r != ZERO_LVL)) begin
                            level_nx_s = level_r - ONE_LVL;
                        end else begin
                            level_nx_s = level_r;
                        end
                        if (level_nx_s == target_s) begin
                            state_nx_s = ST_DONE;
                        end else begin
                            state_nx_s = ST_FADING;
                        end
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nx_s = ST_FADING;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Fade engine state; busy/done are registered decodes of the next state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            level_r     <= FULL_LVL;
            cnt_r       <= {CNT_W{1'b0}};
            dir_r       <= 1'b0;
            fade_busy_r <= 1'b0;
            fade_done_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            level_r     <= level_nx_s;
            cnt_r       <= cnt_nx_s;
            dir_r       <= dir_nx_s;
            fade_busy_r <= (state_nx_s == ST_FADING);
            fade_done_r <= (state_nx_s == ST_DONE);
        end
    end

    assign red       = red_r;
    assign green     = green_r;
    assign blue      = blue_r;
    assign rgb_valid = rgb_valid_r;
    assign level     = level_r;
    assign fade_busy = fade_busy_r;
    assign fade_done = fade_done_r;

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut (INDEX_W=4, COLOR_W=4, LVL_W=3, FADE_DIV=2).
module tb_palette_lut;

    localparam int FADE_DIV = 2;
    // Entry 3 = {8,1,0}, everything else black; entry 0 occupies the MSBs.
    localparam logic [191:0] TB_PAL = {36'h0, 12'h810, 144'h0};

    logic        Clk = 1'b0;
    logic        Reset;
    logic        rd_valid_i;
    logic [3:0]  rd_index;
    logic        wr_en;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        fade_start;
    logic        fade_dir;
    logic        frame_tick;
    logic [3:0]  red, green, blue;
    logic        rgb_valid;
    logic [3:0]  level;
    logic        fade_busy;
    logic        fade_done;
`ifdef PALETTE_COLORKEY_EN
    logic        transparent;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [11:0] m_pal [16];
    logic [11:0] m_s1;
    logic        m_s1_v;
    logic [11:0] m_out;
    logic        m_valid;
    logic        m_trans;
    logic [3:0]  m_level;
    logic        m_fading;
    logic        m_done;
    logic        m_dir;
    int          m_ticks;

    palette_lut #(
        .INDEX_W(4), .COLOR_W(4), .LVL_W(3), .FADE_DIV(FADE_DIV), .DEFAULT_PAL(TB_PAL)
    ) dut (
        .Clk(Clk), .Reset(Reset), .rd_valid_i(rd_valid_i), .rd_index(rd_index),
        .wr_en(wr_en), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .fade_start(fade_start), .fade_dir(fade_dir), .frame_tick(frame_tick),
        .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid),
        .level(level), .fade_busy(fade_busy), .fade_done(fade_done)
`ifdef PALETTE_COLORKEY_EN
        , .transparent(transparent)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] scl(input logic [3:0] c, input logic [3:0] lvl);
        int v;
        v = (int'(c) * int'(lvl)) / 8;
        return 4'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = 12'h000;
        m_pal[3] = 12'h810;
        m_s1 = 12'h000; m_s1_v = 1'b0; m_out = 12'h000; m_valid = 1'b0; m_trans = 1'b0;
        m_level = 4'd8; m_fading = 1'b0; m_done = 1'b0; m_dir = 1'b0; m_ticks = 0;
    endtask

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic model_edge();
        logic was_done;
        logic [3:0] tgt;
        if (m_s1_v) m_out = {scl(m_s1[11:8], m_level), scl(m_s1[7:4], m_level), scl(m_s1[3:0], m_level)};
        m_valid = m_s1_v;
        m_trans = m_s1_v && (m_s1 == 12'hF0F);
        m_s1 = m_pal[rd_index];
        m_s1_v = rd_valid_i;
        if (wr_en) m_pal[wr_index] = wr_rgb;
        was_done = m_done;
        m_done = 1'b0;
        if (!m_fading && !was_done) begin
            if (fade_start) begin
                m_dir = fade_dir;
                tgt = fade_dir ? 4'd8 : 4'd0;
                if (m_level == tgt) m_done = 1'b1;
                else begin m_fading = 1'b1; m_ticks = 0; end
            end
        end else if (m_fading && frame_tick) begin
            m_ticks++;
            if (m_ticks == FADE_DIV) begin
                m_ticks = 0;
                m_level = m_dir ? m_level + 4'd1 : m_level - 4'd1;
                if (m_level == (m_dir ? 4'd8 : 4'd0)) begin
                    m_fading = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rd_valid_i = 1'b0; rd_index = 4'd0; wr_en = 1'b0; wr_index = 4'd0; wr_rgb = 12'h000;
        fade_start = 1'b0; fade_dir = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #1 Reset = 1'b1;
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        @(posedge Clk); @(posedge Clk); #1;
        total++;
        if ({rgb_valid, red, green, blue, level, fade_busy, fade_done} !== {1'b0, 12'h000, 4'd8, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", {rgb_valid, red, green, blue, level, fade_busy, fade_done},
                     {1'b0, 12'h000, 4'd8, 1'b0, 1'b0});
        end
        Reset = 1'b0;
        model_reset();
        rd_valid_i = 1'b1; rd_index = 4'd3;
        step();
        rd_valid_i = 1'b0;
        step();
        total++;
        if ({rgb_valid, red, green, blue, level} !== {1'b1, 12'h810, 4'd8}) begin
            bad++;
            $display("FAIL default_entry3: got %h want %h", {rgb_valid, red, green, blue, level}, {1'b1, 12'h810, 4'd8});
        end
    endtask

    task automatic test_collision();
        wr_en = 1'b1; wr_index = 4'd5; wr_rgb = 12'hABC; rd_valid_i = 1'b1; rd_index = 4'd5;
        step();
        wr_en = 1'b0;
        step();
        total++;
        if ({rgb_valid, red, green, blue} !== {1'b1, 12'h000}) begin
            bad++;
            $display("FAIL collision_old: got %h want %h", {rgb_valid, red, green, blue}, {1'b1, 12'h000});
        end
        rd_valid_i = 1'b0;
        step();
        total++;
        if ({rgb_valid, red, green, blue} !== {1'b1, 12'hABC}) begin
            bad++;
            $display("FAIL collision_new: got %h want %h", {rgb_valid, red, green, blue}, {1'b1, 12'hABC});
        end
        step();
        total++;
        if ({rgb_valid, red, green, blue} !== {1'b0, 12'hABC}) begin
            bad++;
            $display("FAIL hold_invalid: got %h want %h", {rgb_valid, red, green, blue}, {1'b0, 12'hABC});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rd_valid_i = 1'($urandom_range(0, 1));
            rd_index   = 4'($urandom_range(0, 15));
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_index   = 4'($urandom_range(0, 15));
            wr_rgb     = 12'($urandom_range(0, 4095));
            frame_tick = 1'($urandom_range(0, 1));
            fade_start = ($urandom_range(0, 15) == 0);
            fade_dir   = 1'($urandom_range(0, 1));
            step();
            total++;
            if ({rgb_valid, red, green, blue, level, fade_busy, fade_done} !==
                {m_valid, m_out, m_level, m_fading, m_done}) begin
                bad++;
                $display("FAIL random_cycle%0d: got %h want %h", n,
                         {rgb_valid, red, green, blue, level, fade_busy, fade_done},
                         {m_valid, m_out, m_level, m_fading, m_done});
            end
        end
        idle_inputs();
    endtask

    task automatic test_fade_out();
        int ticks = 0;
        int cyc = 0;
        int dones = 0;
        bit seen4 = 0;
        do_reset();
        wr_en = 1'b1; wr_index = 4'd2; wr_rgb = 12'hFED;
        fade_start = 1'b1; fade_dir = 1'b0;
        step();
        idle_inputs();
        while (dones == 0 && cyc < 200) begin
            frame_tick = (cyc % 2 == 0);
            rd_valid_i = 1'b1; rd_index = 4'd2;
            if (frame_tick) ticks++;
            step();
            cyc++;
            total++;
            if ({rgb_valid, red, green, blue, level, fade_busy, fade_done} !==
                {m_valid, m_out, m_level, m_fading, m_done}) begin
                bad++;
                $display("FAIL fade_out_cycle%0d: got %h want %h", cyc,
                         {rgb_valid, red, green, blue, level, fade_busy, fade_done},
                         {m_valid, m_out, m_level, m_fading, m_done});
            end
            if (fade_done) dones++;
            if (!seen4 && level == 4'd4) begin
                seen4 = 1;
                frame_tick = 1'b0;
                step(); step();
                total++;
                if ({red, green, blue} !== 12'h776) begin
                    bad++;
                    $display("FAIL level4_scale: got %h want %h", {red, green, blue}, 12'h776);
                end
            end
        end
        total++;
        if (dones != 1 || ticks != 16) begin
            bad++;
            $display("FAIL fade_out_ticks: got done=%0d ticks=%0d want done=1 ticks=16", dones, ticks);
        end
        frame_tick = 1'b1;
        repeat (4) begin
            step();
            if (fade_done) dones++;
        end
        total++;
        if (dones != 1 || {red, green, blue, level, fade_busy} !== {12'h000, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL fade_out_end: got done=%0d %h want done=1 %h", dones,
                     {red, green, blue, level, fade_busy}, {12'h000, 4'd0, 1'b0});
        end
        idle_inputs();
    endtask

    task automatic test_ignore_restart();
        int cyc = 0;
        bit done_seen = 0;
        fade_start = 1'b1; fade_dir = 1'b1;
        step();
        fade_start = 1'b0;
        while (!done_seen && cyc < 200) begin
            frame_tick = 1'b1;
            fade_start = (cyc == 4); fade_dir = 1'b0;
            step();
            cyc++;
            if (fade_done) done_seen = 1;
            total++;
            if ({level, fade_busy, fade_done} !== {m_level, m_fading, m_done}) begin
                bad++;
                $display("FAIL ignore_cycle%0d: got %h want %h", cyc, {level, fade_busy, fade_done},
                         {m_level, m_fading, m_done});
            end
        end
        total++;
        if (!done_seen || level !== 4'd8) begin
            bad++;
            $display("FAIL ignore_final: got done=%0d level=%0d want done=1 level=8", done_seen, level);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_immediate_done();
        bit done_seen = 0;
        bit busy_seen = 0;
        fade_start = 1'b1; fade_dir = 1'b1;
        step();
        fade_start = 1'b0;
        if (fade_done) done_seen = 1;
        if (fade_busy) busy_seen = 1;
        step();
        if (fade_done) done_seen = 1;
        if (fade_busy) busy_seen = 1;
        total++;
        if (!done_seen || busy_seen || level !== 4'd8) begin
            bad++;
            $display("FAIL immediate_done: got done=%0d busy=%0d level=%0d want done=1 busy=0 level=8",
                     done_seen, busy_seen, level);
        end
    endtask

`ifdef PALETTE_COLORKEY_EN
    task automatic test_colorkey();
        int cyc = 0;
        do_reset();
        wr_en = 1'b1; wr_index = 4'd0; wr_rgb = 12'hF0F;
        step();
        wr_index = 4'd1; wr_rgb = 12'hF20;
        fade_start = 1'b1; fade_dir = 1'b0;
        step();
        idle_inputs();
        while (level != 4'd4 && cyc < 50) begin
            frame_tick = 1'b1;
            step();
            cyc++;
        end
        frame_tick = 1'b0;
        rd_valid_i = 1'b1; rd_index = 4'd0;
        step();
        rd_index = 4'd1;
        step();
        total++;
        if ({transparent, red, green, blue} !== {1'b1, 12'h707}) begin
            bad++;
            $display("FAIL colorkey_hit: got %h want %h", {transparent, red, green, blue}, {1'b1, 12'h707});
        end
        rd_valid_i = 1'b0;
        step();
        total++;
        if ({transparent, red, green, blue} !== {1'b0, 12'h710}) begin
            bad++;
            $display("FAIL colorkey_miss: got %h want %h", {transparent, red, green, blue}, {1'b0, 12'h710});
        end
    endtask
`endif

    task automatic test_reset_mid_fade();
        int dones = 0;
        do_reset();
        fade_start = 1'b1; fade_dir = 1'b0;
        step();
        fade_start = 1'b0;
        frame_tick = 1'b1;
        repeat (5) step();
        #2 Reset = 1'b1;
        #1;
        total++;
        if ({level, fade_busy, fade_done} !== {4'd8, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_fade: got %h want %h", {level, fade_busy, fade_done}, {4'd8, 1'b0, 1'b0});
        end
        @(posedge Clk); #1;
        if (fade_done) dones++;
        Reset = 1'b0;
        model_reset();
        idle_inputs();
        repeat (5) begin
            step();
            if (fade_done) dones++;
        end
        total++;
        if (dones != 0 || {level, fade_busy} !== {4'd8, 1'b0}) begin
            bad++;
            $display("FAIL no_done_after_reset: got done=%0d %h want done=0 %h", dones, {level, fade_busy},
                     {4'd8, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_collision();
        test_random();
        test_fade_out();
        test_ignore_restart();
        test_immediate_done();
`ifdef PALETTE_COLORKEY_EN
        test_colorkey();
`endif
        test_reset_mid_fade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/palette_lut.md
Name: palette_lut

Overview:
Runtime-writable, parametrised colour palette for sprite/background pixel paths: maps a pixel index to RGB through a 2-stage registered pipeline. Adds global brightness scaling driven by a frame-synchronous fade engine, for screen fade-in/fade-out transitions. Sits between the sprite ROM index output and the VGA colour mux.

Parameters:
INDEX_W, 4, index width; entry count NUM_ENTRIES = 2**INDEX_W
COLOR_W, 4, bits per colour channel
LVL_W, 3, brightness resolution; level range 0..2**LVL_W inclusive
FADE_DIV, 2, frame_tick pulses per one-level fade step (>=1)
DEFAULT_PAL, all-zero, NUM_ENTRIES x (3*COLOR_W) reset contents, entry 0 first, {R,G,B} per entry

Ports:
Clk  input  1  system clock, all logic rising-edge
Reset  input  1  asynchronous, active-high
rd_valid_i  input  1  rd_index valid this cycle
rd_index  input  INDEX_W  pixel index to look up
wr_en  input  1  write strobe
wr_index  input  INDEX_W  entry to write
wr_rgb  input  3*COLOR_W  {R,G,B} new entry value
fade_start  input  1  single-cycle request to start a fade
fade_dir  input  1  1 = fade in toward full, 0 = fade out toward black; sampled with fade_start
frame_tick  input  1  one-cycle pulse per frame (vsync edge)
red, green, blue  output  COLOR_W each  scaled colour
rgb_valid  output  1  red/green/blue valid
level  output  LVL_W+1  current brightness level
fade_busy  output  1  fade in progress
fade_done  output  1  one-cycle pulse at fade completion

Behaviour:
- Reset (async, active-high): palette entries <- DEFAULT_PAL; pipeline regs, red/green/blue, rgb_valid, fade_done, fade_busy <- 0; level <- 2**LVL_W (full); FSM <- IDLE; tick counter <- 0. Reset mid-fade aborts with no fade_done.
- Storage: NUM_ENTRIES registers of 3*COLOR_W. wr_en writes wr_index at the clock edge; no handshake, always accepted.
- Read pipeline, fixed latency 2:
  - Stage 1 registers palette[rd_index] and rd_valid_i.
  - Stage 2 registers scaled channels; rgb_valid = rd_valid_i delayed 2 cycles. Stage 2 uses the level value current when stage 1 data enters stage 2.
- Read/write collision (same cycle, same index): read returns the OLD entry; the new value is visible from the next cycle's read.
- Pipeline runs every cycle, no stall. Outputs hold the last computed values when rgb_valid = 0 (not zeroed).
- Scaling per channel: out = (c * level) >> LVL_W, full-width product (COLOR_W+LVL_W+1 bits), truncated. level = 2**LVL_W gives out = c exactly; level = 0 gives 0.
- Fade FSM states: IDLE, FADING, DONE.
  - IDLE: fade_start latches fade_dir as target (full or 0). If level already equals the target -> DONE. Otherwise -> FADING with tick counter cleared.
  - FADING: fade_busy = 1. Each frame_tick increments the counter. When the counter reaches FADE_DIV-1 on a tick, level steps ±1 toward the target and the counter clears. When the new level equals the target -> DONE.
  - DONE: fade_done = 1 for exactly one cycle, fade_busy = 0 -> IDLE.
  - fade_start while FADING or DONE is ignored; the in-progress fade is unaffected.
- level saturates within 0..2**LVL_W; never wraps.

Optional Feature:
PALETTE_COLORKEY_EN. When defined, adds parameter KEY_RGB (default {F,0,F} at COLOR_W=4, i.e. magenta) and output transparent (1 bit, reset 0). transparent is asserted aligned with rgb_valid when the unscaled stage-1 entry equals KEY_RGB; it is independent of level. When undefined, the port and compare logic are absent.

Test Plan:
- Reset with DEFAULT_PAL entry 3 = {8,1,0}; rd_index=3, rd_valid_i=1 at cycle 0 -> cycle 2: rgb={8,1,0}, rgb_valid=1, level=8.
- wr_en, wr_index=5, wr_rgb={A,B,C} with a read of index 5 in the same cycle -> that read returns the old value; a read of index 5 issued the next cycle returns {A,B,C}.
- LVL_W=3, FADE_DIV=2, fade_start, fade_dir=0 -> level 8→0 decrements on every 2nd frame_tick (16 ticks total); fade_done single pulse after level=0; entry {F,E,D} reads {0,0,0}; at level 4 reads {7,7,6}.
- fade_start during FADING with opposite fade_dir -> ignored; fade completes toward the original target.
- fade_start, fade_dir=1 at level=8 -> fade_done pulses within 2 cycles, fade_busy stays 0.
- PALETTE_COLORKEY_EN, entry 0 = {F,0,F}, level=4 -> transparent=1 with rgb={7,0,7}; entry 1 = {F,2,0} -> transparent=0. Assert Reset mid-fade -> level=8, fade_busy=0, no fade_done.
